// File: rtl/mxint8_negate_arb_pkg.sv
// Shared MXINT8 constants plus types for the two-requester negate arbiter.
// The backtick block below stands in for the shared mxint8_includes.v header.
`ifndef MXINT8_INCLUDES_V
`define MXINT8_INCLUDES_V
`define BLOCK_SIZE 32
`define MXINT8_ELEMENT_WIDTH 8
`define MXINT8_UNUSED_ENCODE 8'h80
`endif

package mxint8_negate_arb_pkg;

    localparam int BLOCK_SIZE_DEF = `BLOCK_SIZE;
    localparam int ELEM_W_DEF     = `MXINT8_ELEMENT_WIDTH;
    localparam int SCALE_W_DEF    = 8;
    localparam int CNT_W          = 16;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/mxint8_negate_arb_if.sv
// Requester, result and counter bundle between the arbiter and its neighbours.
// slave is the arbiter's view, master the surrounding logic's view.
interface mxint8_negate_arb_if
    import mxint8_negate_arb_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int ELEM_W     = ELEM_W_DEF,
    parameter int SCALE_W    = SCALE_W_DEF
) ();

    logic                                i_req0_valid;
    logic                                i_req1_valid;
    logic                                o_req0_ready;
    logic                                o_req1_ready;
    logic [SCALE_W-1:0]                  i_req0_scale;
    logic [SCALE_W-1:0]                  i_req1_scale;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0]   i_req0_elements;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0]   i_req1_elements;
    logic                                i_req0_unused_as_zero;
    logic                                i_req1_unused_as_zero;
    logic                                o_valid;
    logic                                i_ready;
    logic [SCALE_W-1:0]                  o_scale;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0]   o_elements;
    logic                                o_grant_id;
    logic [CNT_W-1:0]                    o_done_cnt0;
    logic [CNT_W-1:0]                    o_done_cnt1;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_scale, i_req1_scale,
        input  i_req0_elements, i_req1_elements,
        input  i_req0_unused_as_zero, i_req1_unused_as_zero,
        input  i_ready,
        output o_req0_ready, o_req1_ready,
        output o_valid, o_scale, o_elements, o_grant_id,
        output o_done_cnt0, o_done_cnt1
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_scale, i_req1_scale,
        output i_req0_elements, i_req1_elements,
        output i_req0_unused_as_zero, i_req1_unused_as_zero,
        output i_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_valid, o_scale, o_elements, o_grant_id,
        input  o_done_cnt0, o_done_cnt1
    );

endinterface

// File: rtl/mxint8_negate.sv
// Combinational per-element MXINT8 negate.
// The unused encoding either survives or collapses to zero.
module mxint8_negate
    import mxint8_negate_arb_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int ELEM_W     = ELEM_W_DEF
) (
    input  logic [BLOCK_SIZE-1:0][ELEM_W-1:0] elements,
    input  logic                              unused_as_zero,
    output logic [BLOCK_SIZE-1:0][ELEM_W-1:0] negated
);

    localparam logic [ELEM_W-1:0] UNUSED = ELEM_W'(`MXINT8_UNUSED_ENCODE);

    always_comb begin
        negated = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            // Most-negative code has no positive twin; never wrap it.
            if (elements[i] == UNUSED) begin
                negated[i] = unused_as_zero ? '0 : UNUSED;
            end else begin
                negated[i] = '0 - elements[i];
            end
        end
    end

endmodule

// File: rtl/mxint8_negate_arb.sv
// Two-requester round-robin front end sharing one MXINT8 negate datapath.
// One-deep registered result stage, full throughput, saturating retire counts.
module mxint8_negate_arb
    import mxint8_negate_arb_pkg::*;
#(
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int ELEM_W     = ELEM_W_DEF,
    parameter int SCALE_W    = SCALE_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mxint8_negate_arb_if.slave   bus
);

    logic                              load_en;
    logic                              gnt0;
    logic                              gnt1;
    logic                              acc0;
    logic                              acc1;
    logic                              accept;
    logic                              retire;
    req_id_e                           sel;
    req_id_e                           prio;

    logic [BLOCK_SIZE-1:0][ELEM_W-1:0] mux_elems;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0] neg_elems;
    logic [SCALE_W-1:0]                mux_scale;
    logic                              mux_uaz;

    logic                              valid_q;
    logic [SCALE_W-1:0]                scale_q;
    logic [BLOCK_SIZE-1:0][ELEM_W-1:0] elems_q;
    req_id_e                           id_q;
    logic [CNT_W-1:0]                  cnt0_q;
    logic [CNT_W-1:0]                  cnt1_q;

    always_comb begin
        load_en = !valid_q | bus.i_ready;
        gnt0    = bus.i_req0_valid & ((prio == REQ0) | !bus.i_req1_valid);
        gnt1    = bus.i_req1_valid & ((prio == REQ1) | !bus.i_req0_valid);
        acc0    = load_en & gnt0 & !i_rst;
        acc1    = load_en & gnt1 & !i_rst;
        accept  = acc0 | acc1;
        retire  = valid_q & bus.i_ready;
        sel     = acc1 ? REQ1 : REQ0;
    end

    always_comb begin
        mux_elems = bus.i_req0_elements;
        mux_scale = bus.i_req0_scale;
        mux_uaz   = bus.i_req0_unused_as_zero;
        if (sel == REQ1) begin
            mux_elems = bus.i_req1_elements;
            mux_scale = bus.i_req1_scale;
            mux_uaz   = bus.i_req1_unused_as_zero;
        end
    end

    mxint8_negate #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ELEM_W     (ELEM_W)
    ) u_negate (
        .elements       (mux_elems),
        .unused_as_zero (mux_uaz),
        .negated        (neg_elems)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            scale_q <= '0;
            elems_q <= '0;
            id_q    <= REQ0;
            prio    <= REQ0;
        end else if (accept) begin
            valid_q <= 1'b1;
            scale_q <= mux_scale;
            elems_q <= neg_elems;
            id_q    <= sel;
            prio    <= (sel == REQ0) ? REQ1 : REQ0;
        end else if (retire) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (retire) begin
            if (id_q == REQ0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
            if (id_q == REQ1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign bus.o_req0_ready = acc0;
    assign bus.o_req1_ready = acc1;
    assign bus.o_valid      = valid_q;
    assign bus.o_scale      = scale_q;
    assign bus.o_elements   = elems_q;
    assign bus.o_grant_id   = id_q;
    assign bus.o_done_cnt0  = cnt0_q;
    assign bus.o_done_cnt1  = cnt1_q;

endmodule

// File: tb/tb_mxint8_negate_arb.sv
// Self-checking bench for mxint8_negate_arb: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mxint8_negate_arb;

    localparam int BS = 32;
    localparam int EW = 8;
    localparam int SW = 8;

    typedef logic [BS-1:0][EW-1:0] blk_t;

    typedef struct {
        logic [7:0] elem;
        bit         uaz;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    int   n_cmp;
    int   n_bad;

    // reference model state
    bit         m_valid;
    logic [7:0] m_scale;
    blk_t       m_elems;
    int         m_id;
    int         m_prio;
    int         m_cnt0;
    int         m_cnt1;
    logic       rst;

    mxint8_negate_arb_if #(.BLOCK_SIZE(BS), .ELEM_W(EW), .SCALE_W(SW)) bus ();

    mxint8_negate_arb #(
        .BLOCK_SIZE (BS),
        .ELEM_W     (EW),
        .SCALE_W    (SW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] neg_ref(input int x, input bit uaz);
        if (x == 128) return uaz ? 8'd0 : 8'd128;
        return 8'((256 - x) % 256);
    endfunction

    function automatic bit req_valid(input int k);
        return (k == 1) ? bus.i_req1_valid : bus.i_req0_valid;
    endfunction

    // One clock: check readys from model, advance model, check registers.
    task automatic cycle();
        int   g;
        bit   ld;
        bit   uz;
        blk_t src;
        #2;
        ld = !m_valid || bus.i_ready;
        g  = -1;
        if (!rst && ld) begin
            if (req_valid(m_prio)) g = m_prio;
            else if (req_valid(1 - m_prio)) g = 1 - m_prio;
        end
        check("ready0", 256'(bus.o_req0_ready), 256'(g == 0));
        check("ready1", 256'(bus.o_req1_ready), 256'(g == 1));
        if (rst) begin
            m_valid = 0; m_scale = 0; m_elems = '0;
            m_id = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            if (m_valid && bus.i_ready) begin
                if (m_id == 0 && m_cnt0 < 65535) m_cnt0++;
                if (m_id == 1 && m_cnt1 < 65535) m_cnt1++;
            end
            if (g >= 0) begin
                src = (g == 1) ? bus.i_req1_elements : bus.i_req0_elements;
                uz  = (g == 1) ? bus.i_req1_unused_as_zero
                               : bus.i_req0_unused_as_zero;
                for (int i = 0; i < BS; i++) m_elems[i] = neg_ref(int'(src[i]), uz);
                m_scale = (g == 1) ? bus.i_req1_scale : bus.i_req0_scale;
                m_id    = g;
                m_valid = 1;
                m_prio  = 1 - g;
            end else if (m_valid && bus.i_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check("o_valid", 256'(bus.o_valid), 256'(m_valid));
        check("o_scale", 256'(bus.o_scale), 256'(m_scale));
        check("o_elements", 256'(bus.o_elements), 256'(m_elems));
        check("o_grant_id", 256'(bus.o_grant_id), 256'(m_id));
        check("o_done_cnt0", 256'(bus.o_done_cnt0), 256'(m_cnt0));
        check("o_done_cnt1", 256'(bus.o_done_cnt1), 256'(m_cnt1));
    endtask

    function automatic blk_t fill(input logic [7:0] v);
        blk_t b;
        for (int i = 0; i < BS; i++) b[i] = v;
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BS; i++)
            b[i] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
        return b;
    endfunction

    initial begin
        vec_t tbl[7];
        blk_t held;
        logic prev_id;

        n_cmp = 0;
        n_bad = 0;
        m_valid = 0; m_scale = 0; m_elems = '0;
        m_id = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;

        tbl[0] = '{8'h05, 1'b0, 8'hFB};
        tbl[1] = '{8'h80, 1'b1, 8'h00};
        tbl[2] = '{8'h80, 1'b0, 8'h80};
        tbl[3] = '{8'h7F, 1'b0, 8'h81};
        tbl[4] = '{8'h00, 1'b1, 8'h00};
        tbl[5] = '{8'hFF, 1'b0, 8'h01};
        tbl[6] = '{8'h01, 1'b1, 8'hFF};

        // reset with requesters active: no ready may rise
        rst = 1'b1;
        bus.i_req0_valid = 1; bus.i_req1_valid = 1;
        bus.i_req0_scale = 8'h11; bus.i_req1_scale = 8'h22;
        bus.i_req0_elements = fill(8'h33); bus.i_req1_elements = fill(8'h44);
        bus.i_req0_unused_as_zero = 0; bus.i_req1_unused_as_zero = 0;
        bus.i_ready = 1;
        cycle();
        cycle();
        rst = 1'b0;
        bus.i_req0_valid = 0; bus.i_req1_valid = 0;
        cycle();

        // element vectors through requester 0, each accepted then retired
        foreach (tbl[k]) begin
            bus.i_req0_valid = 1;
            bus.i_req0_scale = (k == 0) ? 8'h7F : 8'(k);
            bus.i_req0_elements = fill(tbl[k].elem);
            bus.i_req0_unused_as_zero = tbl[k].uaz;
            cycle();
            check("vector_elems", 256'(bus.o_elements), 256'(fill(tbl[k].exp)));
            bus.i_req0_valid = 0;
            cycle();
        end

        // both requesters streaming: grants alternate with no bubble
        bus.i_req0_valid = 1; bus.i_req1_valid = 1;
        bus.i_req0_elements = fill(8'h10); bus.i_req1_elements = fill(8'h20);
        cycle();
        prev_id = bus.o_grant_id;
        for (int i = 0; i < 9; i++) begin
            cycle();
            check("alternate", 256'(bus.o_grant_id), 256'(!prev_id));
            check("no_bubble", 256'(bus.o_valid), 256'(1));
            prev_id = bus.o_grant_id;
        end

        // stall three cycles with a held result
        bus.i_ready = 0;
        held = bus.o_elements;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_hold", 256'(bus.o_elements), 256'(held));
        end
        bus.i_ready = 1;
        cycle();

        // reset while a result is stalled
        bus.i_ready = 0;
        cycle();
        rst = 1;
        cycle();
        check("rst_drop", 256'(bus.o_valid), 256'(0));
        rst = 0;
        bus.i_ready = 1;
        cycle();
        check("rst_prio", 256'(bus.o_grant_id), 256'(0));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.i_req0_valid = 1'($urandom_range(0, 1));
            bus.i_req1_valid = 1'($urandom_range(0, 1));
            bus.i_req0_scale = 8'($urandom_range(0, 255));
            bus.i_req1_scale = 8'($urandom_range(0, 255));
            bus.i_req0_elements = rand_blk();
            bus.i_req1_elements = rand_blk();
            bus.i_req0_unused_as_zero = 1'($urandom_range(0, 1));
            bus.i_req1_unused_as_zero = 1'($urandom_range(0, 1));
            bus.i_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
